// File: rtl/bus_capture_fifo.sv
// W-bus capture stage: latches the bus on load, queues the word in a small
// first-word-fall-through FIFO and keeps a copy of the latest accepted word.
module bus_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             load,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] last_value,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] last_q;
    logic             ovf_q;

    logic is_full;
    logic is_empty;
    logic push;
    logic pop;
    logic drop;

    // Handshake: a word transfers on any rising edge where out_valid and
    // out_ready are both high; out_data is stable while valid is held without
    // ready. A pop frees its slot in the same edge, so a full FIFO still
    // accepts a load when the consumer takes the head word.
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_W'(DEPTH));
    assign pop      = !is_empty && out_ready;
    assign push     = load && (!is_full || pop);
    assign drop     = load && is_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                last_q      <= bus_data;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            // A fresh drop outranks a clear in the same cycle.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign out_data   = mem[rd_ptr];
    assign out_valid  = !is_empty;
    assign last_value = last_q;
    assign count      = cnt;
    assign full       = is_full;
    assign empty      = is_empty;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bus_capture_fifo.sv
// Bench for bus_capture_fifo: directed vector table followed by random
// traffic checked against a queue-based model of the FIFO.
module tb_bus_capture_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] bus_data = '0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] last_value;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clear_ovf = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    bus_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_data   (bus_data),
        .load       (load),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .last_value (last_value),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       load;
        logic [7:0] data;
        logic       ready;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        int         cnt;
        logic       ovf;
        logic [7:0] last;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic ld, input logic [7:0] d,
                                input logic rdy, input logic clr, input logic ev,
                                input logic [7:0] ed, input int cnt, input logic ovf,
                                input logic [7:0] last);
        vec_t v;
        v.rst = r; v.load = ld; v.data = d; v.ready = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.cnt = cnt; v.ovf = ovf; v.last = last;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic r, input logic ld, input logic [7:0] d,
                               input logic rdy, input logic clr);
        rst = r; load = ld; bus_data = d; out_ready = rdy; clear_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [7:0] ed,
                               input int cnt, input logic ovf, input logic [7:0] last);
        check({tag, " out_valid"}, int'(out_valid), int'(ev));
        if (ev) check({tag, " out_data"}, int'(out_data), int'(ed));
        check({tag, " count"}, int'(count), cnt);
        check({tag, " full"}, int'(full), int'(cnt == DEPTH));
        check({tag, " empty"}, int'(empty), int'(cnt == 0));
        check({tag, " overflow"}, int'(overflow), int'(ovf));
        check({tag, " last_value"}, int'(last_value), int'(last));
    endtask

    initial begin
        // Reset then idle
        add(1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 8'h00);
        add(1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 8'h00);
        // Single capture and pop
        add(0, 1, 8'hA5, 0, 0,  1, 8'hA5, 1, 0, 8'hA5);
        add(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 8'hA5);
        // Fill, overflow, drain
        add(0, 1, 8'h11, 0, 0,  1, 8'h11, 1, 0, 8'h11);
        add(0, 1, 8'h22, 0, 0,  1, 8'h11, 2, 0, 8'h22);
        add(0, 1, 8'h33, 0, 0,  1, 8'h11, 3, 0, 8'h33);
        add(0, 1, 8'h44, 0, 0,  1, 8'h11, 4, 0, 8'h44);
        add(0, 1, 8'h55, 0, 0,  1, 8'h11, 4, 1, 8'h44);
        add(0, 0, 8'h00, 1, 0,  1, 8'h22, 3, 1, 8'h44);
        add(0, 0, 8'h00, 1, 0,  1, 8'h33, 2, 1, 8'h44);
        add(0, 0, 8'h00, 1, 0,  1, 8'h44, 1, 1, 8'h44);
        add(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 8'h44);
        add(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 8'h44);
        add(0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 8'h44);
        // Full with simultaneous push and pop
        add(0, 1, 8'h11, 0, 0,  1, 8'h11, 1, 0, 8'h11);
        add(0, 1, 8'h22, 0, 0,  1, 8'h11, 2, 0, 8'h22);
        add(0, 1, 8'h33, 0, 0,  1, 8'h11, 3, 0, 8'h33);
        add(0, 1, 8'h44, 0, 0,  1, 8'h11, 4, 0, 8'h44);
        add(0, 1, 8'h55, 1, 0,  1, 8'h22, 4, 0, 8'h55);
        add(0, 0, 8'h00, 1, 0,  1, 8'h33, 3, 0, 8'h55);
        add(0, 0, 8'h00, 1, 0,  1, 8'h44, 2, 0, 8'h55);
        add(0, 0, 8'h00, 1, 0,  1, 8'h55, 1, 0, 8'h55);
        add(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 8'h55);
        // Wrap-around stress: each cycle the head is the word just pushed
        for (int i = 0; i < 10; i++) begin
            add(0, 1, 8'(i), 1, 0,  1, 8'(i), 1, 0, 8'(i));
        end
        add(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 8'h09);
        // Clear priority and mid-operation reset
        add(0, 1, 8'h01, 0, 0,  1, 8'h01, 1, 0, 8'h01);
        add(0, 1, 8'h02, 0, 0,  1, 8'h01, 2, 0, 8'h02);
        add(0, 1, 8'h03, 0, 0,  1, 8'h01, 3, 0, 8'h03);
        add(0, 1, 8'h04, 0, 0,  1, 8'h01, 4, 0, 8'h04);
        add(0, 1, 8'h05, 0, 0,  1, 8'h01, 4, 1, 8'h04);
        add(0, 0, 8'h00, 0, 1,  1, 8'h01, 4, 0, 8'h04);
        add(0, 1, 8'h06, 0, 1,  1, 8'h01, 4, 1, 8'h04);
        add(0, 0, 8'h00, 1, 0,  1, 8'h02, 3, 1, 8'h04);
        add(1, 1, 8'hFF, 1, 0,  0, 8'h00, 0, 0, 8'h00);
        add(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 8'h00);
        add(0, 1, 8'h3C, 0, 0,  1, 8'h3C, 1, 0, 8'h3C);

        foreach (tbl[i]) begin
            drive_cycle(tbl[i].rst, tbl[i].load, tbl[i].data, tbl[i].ready, tbl[i].clr);
            check_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].cnt,
                        tbl[i].ovf, tbl[i].last);
        end

        // Random traffic against a queue model of the FIFO
        begin
            logic [7:0] q[$];
            logic [7:0] m_last;
            logic       m_ovf;
            logic       r, ld, rdy, clr, do_pop, was_full;
            logic [7:0] d;

            drive_cycle(1, 0, 8'h00, 0, 0);
            q.delete();
            m_last = 8'h00;
            m_ovf  = 1'b0;
            for (int c = 0; c < 500; c++) begin
                r   = ($urandom_range(0, 99) < 2);
                ld  = ($urandom_range(0, 99) < 60);
                rdy = ($urandom_range(0, 99) < 45);
                clr = ($urandom_range(0, 99) < 8);
                d   = 8'($urandom);
                if (r) begin
                    q.delete();
                    m_last = 8'h00;
                    m_ovf  = 1'b0;
                end else begin
                    was_full = (q.size() == DEPTH);
                    do_pop   = (q.size() > 0) && rdy;
                    if (do_pop) void'(q.pop_front());
                    if (ld && (!was_full || do_pop)) begin
                        q.push_back(d);
                        m_last = d;
                    end
                    if (ld && was_full && !do_pop) m_ovf = 1'b1;
                    else if (clr) m_ovf = 1'b0;
                end
                drive_cycle(r, ld, d, rdy, clr);
                check_state($sformatf("rnd%0d", c), q.size() > 0,
                            (q.size() > 0) ? q[0] : 8'h00, q.size(), m_ovf, m_last);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_capture_fifo.md
Name: bus_capture_fifo

Overview:
- Receiving end of the shared 8-bit W-bus. Tristate drivers place data on the bus; this block captures the bus value when its load strobe is asserted.
- Captured words are queued in a small first-word-fall-through FIFO and handed to a downstream consumer over a valid/ready handshake.
- Also holds the most recently captured word in a separate register, SAP-1 output-register style.
- Sits between the W-bus and the output/display logic, so the bus owner never stalls on a slow consumer.

Parameters:
- WIDTH, 8, data width of the bus and of every stored word.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_data  input  WIDTH  shared W-bus value, sampled only when load=1.
- load  input  1  capture strobe from the control unit.
- out_data  output  WIDTH  FIFO head word; valid only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head word this cycle.
- last_value  output  WIDTH  most recently accepted captured word.
- count  output  CNT_W  number of words currently stored, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky flag: a load was dropped.
- clear_ovf  input  1  clears overflow.

Behaviour:
- Reset: the sync active-high rst is sampled at the rising edge of clk and overrides all other inputs. It sets to 0:
  - read pointer, write pointer, count
  - every storage entry (so out_data=0)
  - last_value, overflow
  - Also out_valid=0, empty=1, full=0.
- Push:
  - Condition: load=1 AND (full=0 OR pop this cycle).
  - bus_data is written at the write pointer, the write pointer increments modulo DEPTH, and last_value<=bus_data.
- Pop:
  - Condition: out_valid=1 AND out_ready=1.
  - The read pointer increments modulo DEPTH.
  - out_ready while empty has no effect.
- Simultaneous push and pop:
  - count is unchanged.
  - Allowed when full: the pop frees the slot and the push is accepted.
  - When empty, only the push happens. Pop requires out_valid, so push data never bypasses to out_data in the same cycle.
- count:
  - +1 on push only, -1 on pop only, unchanged otherwise.
  - Never exceeds DEPTH and never goes below 0.
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 from just after edge N. This is first-word fall-through, with zero added cycles when the FIFO was empty.
- out_data: driven combinationally from storage[read pointer]. It holds its value while out_valid=1 and out_ready=0.
- Overflow:
  - Condition: load=1 AND full=1 AND no pop.
  - The word is dropped. Storage, pointers, count and last_value are unchanged, and overflow<=1.
  - overflow stays set until clear_ovf=1 or rst.
  - If clear_ovf and a new overflow occur in the same cycle, the set wins (overflow=1).
- Pointer wrap: both pointers wrap from DEPTH-1 to 0. full and empty derive from count, not from pointer equality.
- Reset mid-operation: all queued data is discarded. The first cycle after reset behaves as empty.
- No X/Z handling: bus_data is sampled as-is. The control unit guarantees that exactly one driver is enabled whenever load=1.
- All outputs are registered, or combinational from registers only. There is no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> out_valid=0, empty=1, count=0, out_data=0x00, last_value=0x00, overflow=0.
- Single capture: bus_data=0xA5, load=1 for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=0xA5, last_value=0xA5, count=1. Then out_ready=1 for 1 cycle -> empty=1, count=0.
- Fill and overflow: load 0x11,0x22,0x33,0x44 on consecutive cycles -> full=1, count=4. Then load 0x55 with out_ready=0 -> overflow=1, count=4, last_value=0x44. Drain with out_ready=1 -> out_data sequence 0x11,0x22,0x33,0x44, then empty=1.
- Full with simultaneous push/pop: FIFO full with 0x11..0x44, then load 0x55 and out_ready=1 in the same cycle -> count stays 4, overflow stays 0, last_value=0x55. Drain order 0x22,0x33,0x44,0x55.
- Wrap-around stress: 10 cycles with load=1 and out_ready=1, data 0x00..0x09 starting from empty -> pointers wrap twice. The consumer sees 0x00..0x09 in order, count never exceeds 1, and no overflow.
- Clear priority and mid-op reset: with overflow=1 and full, assert clear_ovf alone -> overflow=0. Assert clear_ovf together with a dropped load -> overflow=1. Assert rst with count=3 -> next cycle count=0, out_valid=0, last_value=0x00.
